countdown_sequencer: RTL and testbench
======================================

Name: countdown_sequencer

Overview:
Run/pause/abort controller for the single-digit seconds display. Loads a preset digit (0-9), counts it down once per second from the 1 kHz project clock, and flags completion with a blinking display. Outputs drive the existing seg7 decoder (digit) and a blanking gate on the segment bus. The block sits between io_in button pins and seg7 in the top-level wrapper.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per countdown second (prescaler terminal count + 1).
BLINK_TICKS, 250, clk cycles per blank/unblank half-period in DONE.

Ports:
clk  input  1  project clock, 1 kHz nominal
reset  input  1  asynchronous, active-high reset
start  input  1  raw start/resume button, asynchronous to clk
stop  input  1  raw pause/abort button, asynchronous to clk
preset  input  4  countdown start value; values >9 clamp to 9
digit  output  4  current digit to seg7, always 0-9
blank  output  1  1 = segments must be forced off
running  output  1  1 while in RUN
done  output  1  1 while in DONE
tick  output  1  one-cycle pulse at each one-second decrement

Behaviour:
- Reset (async, active-high): state=IDLE, digit=0, prescaler=0, blink counter=0, all sync flops=0, blank=running=done=tick=0.
- Button conditioning: start and stop each pass through a 2-flop synchroniser plus a third flop; edge = sync2 & ~sync3. An input going high before rising edge N produces its state effect at edge N+2 (visible after that edge). Held buttons generate exactly one edge. No debounce; a bounce is just further edges.
- Simultaneous start and stop edges in one cycle: stop wins, start ignored.
- Prescaler: width $clog2(TICKS_PER_SEC), counts 0..TICKS_PER_SEC-1 only in RUN, held in PAUSE, cleared in IDLE and DONE.
- IDLE: digit <= min(preset,9) every cycle. Start edge with clamped preset 0 -> DONE. Start edge otherwise -> RUN with prescaler=0. Stop edge: no effect.
- RUN: running=1. On prescaler wrap (count == TICKS_PER_SEC-1) the prescaler returns to 0, tick=1 for that cycle, and digit decrements. If digit was 1, digit becomes 0 and state -> DONE in the same edge. Stop edge -> PAUSE; prescaler and digit are frozen, and a coincident wrap is discarded (no tick, no decrement). Start edge in RUN: ignored.
- PAUSE: running=0, digit held. Start edge -> RUN, resuming prescaler from its held value. Stop edge -> IDLE (abort); digit reloads from preset on the following cycles.
- DONE: done=1, digit=0. The blink counter runs 0..BLINK_TICKS-1. blank toggles at each wrap and starts at 0 on entry. Start or stop edge -> IDLE, with blank cleared and blink counter cleared.
- blank=0 in every state other than DONE. tick=0 outside RUN.
- Digit arithmetic is 4-bit. Digit never wraps below 0 and never exceeds 9.
- Reset asserted mid-operation forces IDLE immediately, without waiting for a clock edge.

Test Plan:
- Reset then preset=5, TICKS_PER_SEC=4: pulse start -> RUN 3 edges later; digit goes 5,4,3,2,1,0 with one tick every 4 cycles; done=1 on the edge digit reaches 0; 5 ticks total.
- Preset=12: in IDLE digit=9. Start -> 9 ticks, then done=1.
- Preset=3, pause after first tick (digit=2) mid-prescaler at count 2: hold 20 cycles, digit stays 2. Resume start -> next tick after exactly 1 more cycle of counting (count 3 wraps).
- PAUSE then stop edge -> IDLE, running=0, digit=preset next cycle. Start and stop edges in same cycle while RUN -> PAUSE.
- Preset=0, start -> DONE directly, no tick. With BLINK_TICKS=2, blank sequence is 0,0,1,1,0,0. A stop edge returns to IDLE with blank=0.
- Assert reset asynchronously between clock edges during RUN with digit=4 -> outputs digit=0, running=0, blank=0 immediately, before any clk edge.

Source files
------------

// File: rtl/countdown_sequencer.sv
// Single-digit seconds countdown with run/pause/abort buttons and a blinking
// completion display; drives the seg7 decoder digit and a segment blanking gate.
module countdown_sequencer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BLINK_TICKS   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset,
  output logic [3:0] digit,
  output logic       blank,
  output logic       running,
  output logic       done,
  output logic       tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_next;
  logic [2:0]      start_sync, stop_sync;
  logic            start_edge, stop_edge;
  logic [PW-1:0]   prescaler;
  logic [BW-1:0]   blink_cnt;
  logic            blank_r;
  logic [3:0]      digit_r;
  logic [3:0]      preset_clamped;
  logic            wrap;

  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign preset_clamped = clamp_digit(preset);
  assign start_edge     = start_sync[1] & ~start_sync[2];
  assign stop_edge      = stop_sync[1] & ~stop_sync[2];
  assign wrap           = (prescaler == PRE_LAST);

  // Button synchronisers: bits [1:0] resynchronise, bit [2] delays for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync <= 3'b000;
      stop_sync  <= 3'b000;
    end else begin
      start_sync <= {start_sync[1:0], start};
      stop_sync  <= {stop_sync[1:0], stop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Stop takes priority over a coincident start in every state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_edge && !stop_edge)
              state_next = (preset_clamped == 4'd0) ? DONE : RUN;
      RUN: begin
        if (stop_edge)                   state_next = PAUSE;
        else if (wrap && digit_r <= 4'd1) state_next = DONE;
      end
      PAUSE: begin
        if (stop_edge)       state_next = IDLE;
        else if (start_edge) state_next = RUN;
      end
      DONE: if (start_edge || stop_edge) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_r   <= 4'd0;
      prescaler <= '0;
      blink_cnt <= '0;
      blank_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          digit_r   <= preset_clamped;
          prescaler <= '0;
          blink_cnt <= '0;
          blank_r   <= 1'b0;
        end
        RUN: begin
          blink_cnt <= '0;
          blank_r   <= 1'b0;
          // A stop edge freezes everything, discarding a coincident wrap
          if (!stop_edge) begin
            if (wrap) begin
              prescaler <= '0;
              digit_r   <= (digit_r > 4'd1) ? digit_r - 4'd1 : 4'd0;
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end
        PAUSE: begin
          blink_cnt <= '0;
          blank_r   <= 1'b0;
        end
        DONE: begin
          digit_r   <= 4'd0;
          prescaler <= '0;
          if (start_edge || stop_edge) begin
            blink_cnt <= '0;
            blank_r   <= 1'b0;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blank_r   <= ~blank_r;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    tick    = 1'b0;
    blank   = 1'b0;
    digit   = digit_r;
    unique case (state)
      IDLE:  ;
      RUN: begin
        running = 1'b1;
        tick    = wrap && !stop_edge;
      end
      PAUSE: ;
      DONE: begin
        done  = 1'b1;
        blank = blank_r;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with a 4-cycle second and 2-cycle blink.
module tb_countdown_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] preset;
  logic [3:0] digit;
  logic       blank;
  logic       running;
  logic       done;
  logic       tick;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  int t0;

  countdown_sequencer #(.TICKS_PER_SEC(4), .BLINK_TICKS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .preset  (preset),
    .digit   (digit),
    .blank   (blank),
    .running (running),
    .done    (done),
    .tick    (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick) tick_cnt++;
  endtask

  // Press for one cycle, then wait until the resulting state change is visible
  task automatic press(input logic s, input logic p);
    start = s;
    stop  = p;
    step();
    start = 1'b0;
    stop  = 1'b0;
    step();
    step();
  endtask

  initial begin
    int exp_blank [6] = '{0, 0, 1, 1, 0, 0};
    reset  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    preset = 4'd0;
    #1 reset = 1'b1;
    #2;
    chk_eq("rst_digit",   32'(digit),   0);
    chk_eq("rst_running", 32'(running), 0);
    chk_eq("rst_done",    32'(done),    0);
    chk_eq("rst_blank",   32'(blank),   0);
    chk_eq("rst_tick",    32'(tick),    0);
    step();
    step();
    reset = 1'b0;

    // Full countdown from 5
    preset = 4'd5;
    step();
    chk_eq("idle_digit5", 32'(digit), 5);
    t0 = tick_cnt;
    press(1'b1, 1'b0);
    chk_eq("run_entry",       32'(running), 1);
    chk_eq("run_entry_digit", 32'(digit),   5);
    for (int k = 0; k < 5; k++) begin
      step(); step(); step();
      chk_eq("tick_pulse", 32'(tick),  1);
      chk_eq("tick_digit", 32'(digit), 5 - k);
      step();
      chk_eq("dec_digit",  32'(digit), 4 - k);
      chk_eq("dec_tick",   32'(tick),  0);
    end
    chk_eq("cd5_done",    32'(done),    1);
    chk_eq("cd5_running", 32'(running), 0);
    chk_eq("cd5_ticks",   tick_cnt - t0, 5);

    // Preset above 9 clamps to 9
    preset = 4'd12;
    press(1'b0, 1'b1);
    chk_eq("done_to_idle", 32'(done), 0);
    step();
    chk_eq("clamp_digit", 32'(digit), 9);
    t0 = tick_cnt;
    press(1'b1, 1'b0);
    for (int i = 0; i < 100 && !done; i++) step();
    chk_eq("cd9_done",  32'(done),  1);
    chk_eq("cd9_ticks", tick_cnt - t0, 9);
    chk_eq("cd9_digit", 32'(digit), 0);

    // Pause mid-prescaler and resume
    preset = 4'd3;
    press(1'b0, 1'b1);
    step();
    chk_eq("idle_digit3", 32'(digit), 3);
    press(1'b1, 1'b0);
    step(); step(); step();
    chk_eq("p_first_tick", 32'(tick), 1);
    step();
    chk_eq("p_digit2", 32'(digit), 2);
    press(1'b0, 1'b1);
    chk_eq("pause_running", 32'(running), 0);
    t0 = tick_cnt;
    for (int i = 0; i < 20; i++) step();
    chk_eq("pause_digit", 32'(digit), 2);
    chk_eq("pause_ticks", tick_cnt - t0, 0);
    press(1'b1, 1'b0);
    chk_eq("resume_running", 32'(running), 1);
    chk_eq("resume_tick0",   32'(tick),    0);
    step();
    chk_eq("resume_tick1", 32'(tick),  1);
    chk_eq("resume_digit", 32'(digit), 2);
    step();
    chk_eq("resume_dec", 32'(digit), 1);

    // Simultaneous start+stop in RUN pauses; stop in PAUSE aborts
    press(1'b1, 1'b1);
    chk_eq("both_running", 32'(running), 0);
    chk_eq("both_done",    32'(done),    0);
    chk_eq("both_digit",   32'(digit),   1);
    preset = 4'd7;
    press(1'b0, 1'b1);
    chk_eq("abort_running", 32'(running), 0);
    chk_eq("abort_digit",   32'(digit),   1);
    step();
    chk_eq("abort_reload", 32'(digit), 7);

    // Preset 0 goes straight to DONE and blinks
    preset = 4'd0;
    step();
    t0 = tick_cnt;
    press(1'b1, 1'b0);
    chk_eq("zero_done",  32'(done),  1);
    chk_eq("zero_ticks", tick_cnt - t0, 0);
    chk_eq("zero_digit", 32'(digit), 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      chk_eq("blank_seq", 32'(blank), exp_blank[i]);
    end
    press(1'b0, 1'b1);
    chk_eq("blink_exit_blank", 32'(blank), 0);
    chk_eq("blink_exit_done",  32'(done),  0);

    // Asynchronous reset during RUN
    preset = 4'd5;
    step();
    press(1'b1, 1'b0);
    step(); step(); step(); step();
    chk_eq("pre_reset_digit", 32'(digit), 4);
    #2 reset = 1'b1;
    #1;
    chk_eq("areset_digit",   32'(digit),   0);
    chk_eq("areset_running", 32'(running), 0);
    chk_eq("areset_blank",   32'(blank),   0);
    chk_eq("areset_tick",    32'(tick),    0);
    step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
